// File: rtl/dual_port_ram_arbiter.sv
// Round-robin arbiter that maps up to two compatible requests per cycle onto
// the two ports of a shared dual-port RAM, registering read data per requester.
module dual_port_ram_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [NREQ*DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]        ram_addr_A,
  output logic [DATA_W-1:0]        ram_din_A,
  output logic                     ram_mode_A,
  input  logic [DATA_W-1:0]        ram_dout_A,
  output logic [ADDR_W-1:0]        ram_addr_B,
  output logic [DATA_W-1:0]        ram_din_B,
  output logic                     ram_mode_B,
  input  logic [DATA_W-1:0]        ram_dout_B,
  output logic [CNT_W-1:0]         conflict_cnt
);

  localparam int          PW     = $clog2(NREQ);
  localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

  logic [PW-1:0]     r_rr;
  logic [CNT_W-1:0]  r_cnt;
  logic [NREQ-1:0]   r_rvalid;
  logic [DATA_W-1:0] r_rdata [NREQ];

  logic [ADDR_W-1:0] w_addr  [NREQ];
  logic [DATA_W-1:0] w_wdata [NREQ];
  logic              w_a_fnd, w_b_fnd, w_a_v, w_b_v, w_skip;
  logic [PW-1:0]     w_a_idx, w_b_idx, w_next_rr;
  logic [NREQ-1:0]   w_gnt_a, w_gnt_b, w_rd_a, w_rd_b;

  function automatic logic [PW-1:0] f_wrap(input logic [PW:0] v);
    return (v >= NREQ_W) ? PW'(v - NREQ_W) : v[PW-1:0];
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    assign w_addr[g]                  = req_addr[g*ADDR_W +: ADDR_W];
    assign w_wdata[g]                 = req_wdata[g*DATA_W +: DATA_W];
    assign rdata[g*DATA_W +: DATA_W]  = r_rdata[g];
  end

  // Single scan from rr_ptr: first requester takes port A; later requesters
  // either become port B (first compatible one) or count as conflict skips.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    w_a_fnd = 1'b0;
    w_b_fnd = 1'b0;
    w_a_idx = '0;
    w_b_idx = '0;
    w_skip  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = f_wrap({1'b0, r_rr} + (PW+1)'(k));
      if (req[idx]) begin
        if (!w_a_fnd) begin
          w_a_fnd = 1'b1;
          w_a_idx = idx;
        end else if (!w_b_fnd) begin
          if (w_addr[idx] != w_addr[w_a_idx] || (!req_we[idx] && !req_we[w_a_idx])) begin
            w_b_fnd = 1'b1;
            w_b_idx = idx;
          end else begin
            w_skip = 1'b1;
          end
        end
      end
    end
  end

  // Gating with rst_n keeps the RAM idle so no write commits during reset.
  assign w_a_v = w_a_fnd & rst_n;
  assign w_b_v = w_b_fnd & rst_n;

  always_comb begin
    w_gnt_a = '0;
    w_gnt_b = '0;
    if (w_a_v) w_gnt_a[w_a_idx] = 1'b1;
    if (w_b_v) w_gnt_b[w_b_idx] = 1'b1;
  end

  assign gnt    = w_gnt_a | w_gnt_b;
  assign w_rd_a = w_gnt_a & ~req_we;
  assign w_rd_b = w_gnt_b & ~req_we;

  assign ram_mode_A = w_a_v & req_we[w_a_idx];
  assign ram_addr_A = w_a_v ? w_addr[w_a_idx]  : '0;
  assign ram_din_A  = w_a_v ? w_wdata[w_a_idx] : '0;
  assign ram_mode_B = w_b_v & req_we[w_b_idx];
  assign ram_addr_B = w_b_v ? w_addr[w_b_idx]  : '0;
  assign ram_din_B  = w_b_v ? w_wdata[w_b_idx] : '0;

  assign w_next_rr = f_wrap({1'b0, (w_b_v ? w_b_idx : w_a_idx)} + (PW+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_a_v) r_rr <= w_next_rr;
      if (w_skip && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= '0;
      for (int i = 0; i < NREQ; i++) r_rdata[i] <= '0;
    end else begin
      r_rvalid <= w_rd_a | w_rd_b;
      for (int i = 0; i < NREQ; i++) begin
        if (w_rd_a[i])      r_rdata[i] <= ram_dout_A;
        else if (w_rd_b[i]) r_rdata[i] <= ram_dout_B;
      end
    end
  end

  assign rvalid       = r_rvalid;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// Bench for dual_port_ram_arbiter: directed scenarios plus random traffic,
// checked against a scan-order reference model and a shadow memory.
module tb_dual_port_ram_arbiter;
  localparam int NREQ = 4, ADDR_W = 6, DATA_W = 8, CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic                   clk = 1'b0, rst_n;
  logic [NREQ-1:0]        req, req_we, gnt, rvalid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata, rdata;
  logic [ADDR_W-1:0]      ram_addr_A, ram_addr_B;
  logic [DATA_W-1:0]      ram_din_A, ram_din_B, ram_dout_A, ram_dout_B;
  logic                   ram_mode_A, ram_mode_B;
  logic [CNT_W-1:0]       conflict_cnt;

  dual_port_ram_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_addr_A(ram_addr_A), .ram_din_A(ram_din_A), .ram_mode_A(ram_mode_A), .ram_dout_A(ram_dout_A),
    .ram_addr_B(ram_addr_B), .ram_din_B(ram_din_B), .ram_mode_B(ram_mode_B), .ram_dout_B(ram_dout_B),
    .conflict_cnt(conflict_cnt));

  always #5 clk = ~clk;

  // The RAM being shared: sync write, async read.
  logic [DATA_W-1:0] ram_mem [64];
  always @(posedge clk) begin
    if (ram_mode_A) ram_mem[ram_addr_A] <= ram_din_A;
    if (ram_mode_B) ram_mem[ram_addr_B] <= ram_din_B;
  end
  assign ram_dout_A = ram_mem[ram_addr_A];
  assign ram_dout_B = ram_mem[ram_addr_B];

  bit                t_req [NREQ];
  bit                t_we  [NREQ];
  logic [ADDR_W-1:0] t_addr[NREQ];
  logic [DATA_W-1:0] t_wd  [NREQ];

  logic [DATA_W-1:0] m_mem [64];
  int                m_rr, m_cnt;
  bit                m_rv  [NREQ];
  logic [DATA_W-1:0] m_rd  [NREQ];
  int                e_a, e_b;
  bit                e_skip;
  logic [NREQ-1:0]   e_gnt;

  int n_chk = 0, n_pass = 0;
  int rv_cnt [NREQ];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i]                         = t_req[i];
      req_we[i]                      = t_we[i];
      req_addr[i*ADDR_W +: ADDR_W]   = t_addr[i];
      req_wdata[i*DATA_W +: DATA_W]  = t_wd[i];
    end
  endtask

  task automatic clr_all();
    for (int i = 0; i < NREQ; i++) begin
      t_req[i] = 0; t_we[i] = 0; t_addr[i] = '0; t_wd[i] = '0;
    end
    drive();
  endtask

  task automatic set_req(input int i, input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    t_req[i] = 1; t_we[i] = we; t_addr[i] = a; t_wd[i] = d;
    drive();
  endtask

  task automatic m_reset();
    m_rr = 0; m_cnt = 0;
    for (int i = 0; i < NREQ; i++) begin m_rv[i] = 0; m_rd[i] = '0; end
  endtask

  // List the requesters in round-robin order; the head takes port A, the
  // first later one that may coexist with it takes port B.
  task automatic model_comb();
    int order[$];
    int idx;
    e_a = -1; e_b = -1; e_skip = 0; e_gnt = '0;
    if (rst_n !== 1'b1) return;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_rr + k) % NREQ;
      if (t_req[idx]) order.push_back(idx);
    end
    if (order.size() == 0) return;
    e_a = order[0];
    for (int n = 1; n < order.size(); n++) begin
      if (t_addr[order[n]] != t_addr[e_a] || (!t_we[order[n]] && !t_we[e_a])) begin
        e_b = order[n];
        break;
      end
      e_skip = 1;
    end
    e_gnt[e_a] = 1'b1;
    if (e_b >= 0) e_gnt[e_b] = 1'b1;
  endtask

  task automatic model_seq();
    for (int i = 0; i < NREQ; i++) m_rv[i] = 0;
    for (int i = 0; i < NREQ; i++)
      if (e_gnt[i] && !t_we[i]) begin m_rd[i] = m_mem[t_addr[i]]; m_rv[i] = 1; end
    for (int i = 0; i < NREQ; i++)
      if (e_gnt[i] && t_we[i]) m_mem[t_addr[i]] = t_wd[i];
    if (e_a >= 0) m_rr = (((e_b >= 0) ? e_b : e_a) + 1) % NREQ;
    if (e_skip && m_cnt < CMAX) m_cnt++;
  endtask

  task automatic post_chk();
    for (int i = 0; i < NREQ; i++) begin
      chk($sformatf("rvalid%0d", i), rvalid[i], m_rv[i]);
      chk($sformatf("rdata%0d", i), rdata[i*DATA_W +: DATA_W], m_rd[i]);
      if (rvalid[i]) rv_cnt[i]++;
    end
    chk("conflict_cnt", conflict_cnt, m_cnt);
  endtask

  task automatic port_chk();
    logic ma, mb;
    logic [ADDR_W-1:0] aa, ab;
    ma = 0; mb = 0; aa = '0; ab = '0;
    if (e_a >= 0) begin ma = t_we[e_a]; aa = t_addr[e_a]; end
    if (e_b >= 0) begin mb = t_we[e_b]; ab = t_addr[e_b]; end
    chk("gnt", gnt, e_gnt);
    chk("mode_A", ram_mode_A, ma);
    chk("addr_A", ram_addr_A, aa);
    chk("mode_B", ram_mode_B, mb);
    chk("addr_B", ram_addr_B, ab);
    if (ma) chk("din_A", ram_din_A, t_wd[e_a]);
    if (mb) chk("din_B", ram_din_B, t_wd[e_b]);
  endtask

  task automatic step();
    @(negedge clk);
    model_comb();
    port_chk();
    @(posedge clk); #1;
    model_seq();
    post_chk();
  endtask

  initial begin
    for (int a = 0; a < 64; a++) begin ram_mem[a] = '0; m_mem[a] = '0; end
    for (int i = 0; i < NREQ; i++) rv_cnt[i] = 0;
    m_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin t_req[i] = 1; t_we[i] = 1; t_addr[i] = 6'(i); t_wd[i] = 8'hFF; end
    drive();

    // Reset with everyone requesting writes: nothing may reach the RAM.
    #2;
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_modeA", ram_mode_A, 0);
    chk("rst_modeB", ram_mode_B, 0);
    chk("rst_cnt", conflict_cnt, 0);
    @(posedge clk); #1;
    post_chk();
    clr_all();
    rst_n = 1'b1;

    // Write then read back.
    set_req(0, 1, 6'h10, 8'hA5); step();
    clr_all(); set_req(0, 0, 6'h10, 8'h00); step();
    chk("t2_rdata0", rdata[7:0], 8'hA5);
    clr_all(); step();

    // Dual grant with rr_ptr at 1, then req3 reads the word req2 wrote.
    set_req(1, 0, 6'h03, 8'h00); set_req(2, 1, 6'h04, 8'h3C); step();
    clr_all(); set_req(3, 0, 6'h04, 8'h00); step();
    chk("t3_rdata3", rdata[31:24], 8'h3C);

    // Same-address write conflict.
    clr_all(); set_req(0, 1, 6'h20, 8'h11); set_req(1, 1, 6'h20, 8'h22); step();
    chk("t4_cnt", conflict_cnt, 1);
    t_req[0] = 0; drive(); step();
    clr_all(); set_req(2, 0, 6'h20, 8'h00); step();
    chk("t4_mem", rdata[23:16], 8'h22);

    // Fairness from a fresh pointer: four readers, eight cycles.
    clr_all();
    rst_n = 1'b0; m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) begin rv_cnt[i] = 0; set_req(i, 0, 6'($urandom), 8'h00); end
    for (int c = 0; c < 8; c++) step();
    for (int i = 0; i < NREQ; i++) chk($sformatf("t5_rvcnt%0d", i), rv_cnt[i], 4);

    // Reset arriving while a read grant is in flight.
    clr_all(); set_req(3, 1, 6'h05, 8'h77); step();
    clr_all(); set_req(3, 0, 6'h05, 8'h00); step();
    @(negedge clk);
    model_comb();
    chk("t6_gnt", gnt, 4'b1000);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_gnt_rst", gnt, 0);
    chk("t6_rvalid3", rvalid[3], 0);
    chk("t6_rdata3", rdata[31:24], 0);
    m_reset();
    @(posedge clk); #1;
    post_chk();
    clr_all();
    rst_n = 1'b1;

    // Random traffic, narrow address range to provoke conflicts.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!t_req[i] && $urandom_range(0, 3) != 0) begin
          t_req[i] = 1;
          t_we[i]  = 1'($urandom);
          t_addr[i] = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 3));
          t_wd[i]  = 8'($urandom);
        end
      drive();
      step();
      for (int i = 0; i < NREQ; i++) if (e_gnt[i]) t_req[i] = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
